// File: rtl/ad_block_packer_if.sv
// Bundles the byte-stream, fill-request and finished-block signals of the
// AD block packer. The "slave" modport is the packer's view; the "master"
// modport is the source/loader side that drives it.
`timescale 1ns/1ps
interface ad_block_packer_if #(
    parameter int RATE_BYTES = 8
);
    localparam int LEN_W = $clog2(RATE_BYTES + 1);

    logic                    fill_req;
    logic [LEN_W-1:0]        datalen;
    logic [7:0]              byte_in;
    logic                    byte_valid;
    logic                    byte_ready;
    logic [RATE_BYTES*8-1:0] blk_data;
    logic [LEN_W-1:0]        blk_len;
    logic                    blk_valid;
    logic                    blk_ack;
    logic                    busy;

    modport slave (
        input  fill_req, datalen, byte_in, byte_valid, blk_ack,
        output byte_ready, blk_data, blk_len, blk_valid, busy
    );

    modport master (
        output fill_req, datalen, byte_in, byte_valid, blk_ack,
        input  byte_ready, blk_data, blk_len, blk_valid, busy
    );
endinterface

// File: rtl/ad_block_packer.sv
// Assembles associated-data bytes from a byte-wide valid/ready stream into
// one rate block, applies 10* padding to partial blocks and holds the result
// until the consumer acknowledges it.
`timescale 1ns/1ps
module ad_block_packer #(
    parameter int          RATE_BYTES = 8,
    parameter logic [7:0]  PAD_BYTE   = 8'h80
) (
    input  logic             clk,
    input  logic             RST,
    ad_block_packer_if.slave bus
);
    localparam int LEN_W = $clog2(RATE_BYTES + 1);
    localparam int IDX_W = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, FILL, PAD, HOLD} state_t;

    state_t                     state, state_nxt;
    logic [LEN_W-1:0]           len, count, len_sat;
    logic [RATE_BYTES-1:0][7:0] lanes;      // lanes[k] holds data byte k
    logic                       xfer, last;

    // Oversized requests saturate to a full block.
    always_comb begin
        len_sat = bus.datalen;
        if (bus.datalen > LEN_W'(RATE_BYTES))
            len_sat = LEN_W'(RATE_BYTES);
    end

    // byte_ready is exactly "state == FILL", so a transfer only needs valid.
    assign xfer = (state == FILL) && bus.byte_valid;
    assign last = xfer && (count == len - LEN_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.fill_req)
                      state_nxt = (len_sat == '0) ? PAD : FILL;
            FILL: if (last)
                      state_nxt = (len == LEN_W'(RATE_BYTES)) ? HOLD : PAD;
            PAD:  state_nxt = HOLD;
            HOLD: if (bus.blk_ack)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decode straight from the state.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.blk_valid  = 1'b0;
        bus.busy       = 1'b0;
        case (state)
            FILL: begin bus.byte_ready = 1'b1; bus.busy = 1'b1; end
            PAD:  bus.busy = 1'b1;
            HOLD: begin bus.blk_valid = 1'b1; bus.busy = 1'b1; end
            default: ;
        endcase
    end

    // Block length and byte counter; the counter stops at len, never wraps.
    always_ff @(posedge clk) begin
        if (RST) begin
            len   <= '0;
            count <= '0;
        end else if (state == IDLE && bus.fill_req) begin
            len   <= len_sat;
            count <= '0;
        end else if (xfer) begin
            count <= count + LEN_W'(1);
        end
    end

    assign bus.blk_len = len;

    // Per-lane storage: cleared on a new fill, loaded by the matching transfer,
    // or loaded with the pad byte when this lane directly follows the data.
    for (genvar k = 0; k < RATE_BYTES; k++) begin : g_lane
        always_ff @(posedge clk) begin
            if (RST)
                lanes[k] <= '0;
            else if (state == IDLE && bus.fill_req)
                lanes[k] <= '0;
            else if (xfer && count[IDX_W-1:0] == IDX_W'(k))
                lanes[k] <= bus.byte_in;
            else if (state == PAD && len[IDX_W-1:0] == IDX_W'(k))
                lanes[k] <= PAD_BYTE;
        end

        // Byte 0 sits in the most significant position of the block.
        assign bus.blk_data[8*(RATE_BYTES-1-k) +: 8] = lanes[k];
    end
endmodule

// File: tb/tb_ad_block_packer.sv
// Directed self-checking bench for ad_block_packer.
`timescale 1ns/1ps
module tb_ad_block_packer;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_acc;
    int   n_rdy;
    logic [7:0] pat;
    logic [7:0] nxt_byte;

    ad_block_packer_if #(.RATE_BYTES(8)) bus ();

    ad_block_packer #(.RATE_BYTES(8), .PAD_BYTE(8'h80)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.fill_req   = 1'b0;
        bus.datalen    = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.blk_ack    = 1'b0;

        // Reset state
        step(); step();
        chk("rst_ready", 64'(bus.byte_ready), 64'd0);
        chk("rst_valid", 64'(bus.blk_valid), 64'd0);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_data",  bus.blk_data, 64'd0);
        chk("rst_len",   64'(bus.blk_len), 64'd0);
        RST = 1'b0;
        step();

        // Full block of 8, back-to-back bytes 01..08
        bus.fill_req = 1'b1; bus.datalen = 4'd8;
        bus.byte_valid = 1'b1; bus.byte_in = 8'h01;
        step();
        bus.fill_req = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            bus.byte_in = 8'(i + 1);
            if (bus.byte_ready) n_rdy++;
            step();
        end
        bus.byte_valid = 1'b0;
        chk("f8_ready_cycles", 64'(n_rdy), 64'd8);
        chk("f8_ready_off",    64'(bus.byte_ready), 64'd0);
        chk("f8_valid",        64'(bus.blk_valid), 64'd1);
        chk("f8_data",         bus.blk_data, 64'h0102030405060708);
        chk("f8_len",          64'(bus.blk_len), 64'd8);
        bus.blk_ack = 1'b1;
        step();
        bus.blk_ack = 1'b0;
        chk("f8_ack_valid", 64'(bus.blk_valid), 64'd0);
        chk("f8_ack_busy",  64'(bus.busy), 64'd0);

        // Partial block of 3: AA BB CC then pad
        bus.fill_req = 1'b1; bus.datalen = 4'd3;
        step();
        bus.fill_req = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'hAA; step();
        bus.byte_in = 8'hBB; step();
        bus.byte_in = 8'hCC; step();
        bus.byte_valid = 1'b0;
        chk("p3_pad_valid", 64'(bus.blk_valid), 64'd0);
        chk("p3_pad_ready", 64'(bus.byte_ready), 64'd0);
        step();
        chk("p3_valid", 64'(bus.blk_valid), 64'd1);
        chk("p3_data",  bus.blk_data, 64'hAABBCC8000000000);
        chk("p3_len",   64'(bus.blk_len), 64'd3);
        bus.blk_ack = 1'b1; step(); bus.blk_ack = 1'b0;

        // Empty block: pad only
        bus.fill_req = 1'b1; bus.datalen = 4'd0;
        step();
        bus.fill_req = 1'b0;
        chk("e0_ready1", 64'(bus.byte_ready), 64'd0);
        chk("e0_valid1", 64'(bus.blk_valid), 64'd0);
        chk("e0_busy1",  64'(bus.busy), 64'd1);
        step();
        chk("e0_ready2", 64'(bus.byte_ready), 64'd0);
        chk("e0_valid2", 64'(bus.blk_valid), 64'd1);
        chk("e0_data",   bus.blk_data, 64'h8000000000000000);
        chk("e0_len",    64'(bus.blk_len), 64'd0);
        bus.blk_ack = 1'b1; step(); bus.blk_ack = 1'b0;

        // datalen=5 with a stalling source; valid pattern 1,0,0,1,1,0,1,1
        pat = 8'b1101_1001;
        nxt_byte = 8'h11;
        n_acc = 0;
        bus.fill_req = 1'b1; bus.datalen = 4'd5;
        step();
        bus.fill_req = 1'b0;
        for (int p = 0; p < 8; p++) begin
            bus.byte_valid = pat[p];
            bus.byte_in    = pat[p] ? nxt_byte : 8'hEE;
            if (bus.byte_valid && bus.byte_ready) n_acc++;
            step();
            if (pat[p]) nxt_byte = nxt_byte + 8'h11;
        end
        // A sixth byte is offered but must not be taken
        bus.byte_valid = 1'b1; bus.byte_in = nxt_byte;
        chk("s5_ready_off", 64'(bus.byte_ready), 64'd0);
        step();
        chk("s5_valid",    64'(bus.blk_valid), 64'd1);
        chk("s5_accepted", 64'(n_acc), 64'd5);
        chk("s5_data",     bus.blk_data, 64'h1122334455800000);
        chk("s5_len",      64'(bus.blk_len), 64'd5);
        step();
        chk("s5_hold_ready", 64'(bus.byte_ready), 64'd0);
        chk("s5_hold_data",  bus.blk_data, 64'h1122334455800000);
        bus.byte_valid = 1'b0;
        bus.blk_ack = 1'b1; step(); bus.blk_ack = 1'b0;

        // datalen=12 saturates; fill_req/blk_ack during FILL are ignored
        bus.fill_req = 1'b1; bus.datalen = 4'd12;
        step();
        chk("sat_len", 64'(bus.blk_len), 64'd8);
        bus.datalen = 4'd2; bus.blk_ack = 1'b1;
        step();
        bus.fill_req = 1'b0; bus.blk_ack = 1'b0;
        chk("sat_still_fill", 64'(bus.byte_ready), 64'd1);
        chk("sat_len_kept",   64'(bus.blk_len), 64'd8);
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.byte_in = 8'hF0 + 8'(i);
            step();
        end
        bus.byte_valid = 1'b0;
        chk("sat_valid", 64'(bus.blk_valid), 64'd1);
        chk("sat_data",  bus.blk_data, 64'hF0F1F2F3F4F5F6F7);
        // fill_req together with blk_ack must not start a new fill
        bus.blk_ack = 1'b1; bus.fill_req = 1'b1; bus.datalen = 4'd4;
        step();
        bus.blk_ack = 1'b0; bus.fill_req = 1'b0;
        chk("ackreq_busy1", 64'(bus.busy), 64'd0);
        step();
        chk("ackreq_busy2", 64'(bus.busy), 64'd0);

        // Reset mid-fill after 2 of 6 bytes
        bus.fill_req = 1'b1; bus.datalen = 4'd6;
        step();
        bus.fill_req = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h31; step();
        bus.byte_in = 8'h32; step();
        bus.byte_valid = 1'b0;
        RST = 1'b1;
        step();
        chk("mrst_ready", 64'(bus.byte_ready), 64'd0);
        chk("mrst_valid", 64'(bus.blk_valid), 64'd0);
        chk("mrst_busy",  64'(bus.busy), 64'd0);
        chk("mrst_data",  bus.blk_data, 64'd0);
        chk("mrst_len",   64'(bus.blk_len), 64'd0);
        RST = 1'b0;
        step();
        bus.fill_req = 1'b1; bus.datalen = 4'd1;
        step();
        bus.fill_req = 1'b0;
        bus.byte_valid = 1'b1; bus.byte_in = 8'h5A;
        step();
        bus.byte_valid = 1'b0;
        step();
        chk("r1_valid", 64'(bus.blk_valid), 64'd1);
        chk("r1_data",  bus.blk_data, 64'h5A80000000000000);
        chk("r1_len",   64'(bus.blk_len), 64'd1);
        bus.blk_ack = 1'b1; step(); bus.blk_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ad_block_packer.md
Name: ad_block_packer

Overview:
- Upstream feeder of the AD loader stage.
- Collects associated-data bytes from a byte-wide valid/ready stream and assembles them into one rate-sized block (64 bits by default).
- Applies ASCON 10* padding to partial blocks.
- Holds the finished block until the consumer acknowledges it with its read pulse.
- Block length for each fill comes from the loader's datalen output.

Parameters:
RATE_BYTES, 8, bytes per rate block; block width is RATE_BYTES*8.
PAD_BYTE, 8'h80, value written to the first lane after the last data byte of a partial block.

Ports:
clk  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
fill_req  input  1  start assembling one block; sampled only in IDLE
datalen  input  4  data bytes in this block, 0..8; sampled with fill_req; values >8 saturate to 8
byte_in  input  8  AD byte from the source
byte_valid  input  1  byte_in valid
byte_ready  output  1  packer accepts byte_in this cycle
blk_data  output  64  assembled block; byte 0 at [63:56], byte k at [63-8k -: 8]
blk_len  output  4  latched length of the held block
blk_valid  output  1  blk_data/blk_len valid and stable
blk_ack  input  1  consumer has read the block (connects to AD_read)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset:
  - On RST high at a clock edge: state=IDLE, byte_ready=0, blk_valid=0, busy=0, blk_data=0, blk_len=0, internal byte count=0.
  - Reset mid-operation drops any partial block with no further handshake.
- State machine: IDLE, FILL, PAD, HOLD.
- IDLE:
  - byte_ready=0.
  - On fill_req: latch len=min(datalen,8), clear blk_data to 0, clear count.
  - If len==0, go to PAD; otherwise go to FILL.
  - fill_req in any other state is ignored.
- FILL:
  - byte_ready=1.
  - A transfer occurs when byte_valid and byte_ready are both high in the same cycle.
  - Each transfer writes byte_in into lane count, then count increments.
  - No transfer leaves the state unchanged; the source may stall indefinitely.
  - On the transfer where count==len-1:
    - If len==8, go to HOLD (no padding in this block).
    - Else go to PAD.
  - byte_ready drops in the cycle after the last transfer; at most len bytes are ever accepted.
- PAD:
  - One cycle, byte_ready=0.
  - Writes PAD_BYTE into lane len; remaining lanes stay 0.
  - Go to HOLD.
- HOLD:
  - blk_valid=1; blk_data and blk_len are stable.
  - On blk_ack, go to IDLE; blk_valid is low the next cycle.
  - blk_ack outside HOLD is ignored.
  - fill_req in the same cycle as blk_ack is ignored; a new fill needs fill_req while in IDLE.
- Latency:
  - fill_req to first byte_ready: 1 cycle.
  - Last byte of a len=8 block to blk_valid: 1 cycle.
  - Last byte of a len 1..7 block to blk_valid: 2 cycles.
  - fill_req with len=0 to blk_valid: 2 cycles.
  - Minimum block-to-block spacing: HOLD→IDLE→next fill, i.e. one IDLE cycle.
- Width rules:
  - count is 4 bits and never exceeds len; no wrap.
  - Lane index is count[2:0]; PAD lane is len[2:0] and never reaches 8.
- busy is high in FILL, PAD and HOLD.

Test Plan:
- Reset, then fill_req with datalen=8 and bytes 01..08 streamed back-to-back -> byte_ready high for exactly 8 cycles; blk_valid 1 cycle after the last byte; blk_data=64'h0102030405060708, blk_len=8; blk_ack -> blk_valid low next cycle, busy low.
- fill_req with datalen=3, bytes AA,BB,CC -> blk_data=64'hAABBCC8000000000, blk_len=3; blk_valid 2 cycles after the CC transfer.
- fill_req with datalen=0, no bytes sent -> blk_data=64'h8000000000000000, blk_valid 2 cycles after fill_req, byte_ready never high.
- datalen=5 with byte_valid toggling 1,0,0,1,1,0,1,1 -> exactly 5 bytes accepted in order; byte_ready low after the 5th; correct padding at lane 5; a 6th valid byte is not consumed.
- datalen=12 -> treated as 8 (blk_len=8); fill_req and blk_ack pulsed while in FILL -> no effect.
- RST asserted after 2 of 6 bytes -> all outputs at reset values next cycle; a subsequent fill_req with datalen=1, byte 5A -> blk_data=64'h5A80000000000000.
